// File: rtl/axi_burst_sequencer.sv
// ----------------------------------------------------------------------------
// axi_burst_sequencer
//
// Purpose:
//   Accepts AXI-style burst descriptors (address, len, size, burst type) and
//   expands each legal one into a stream of beat addresses, one per cycle
//   while the consumer is ready. Supports FIXED, INCR (wrapping inside the
//   4 KiB page) and WRAP bursts. Illegal descriptors are accepted, flagged
//   with a one-cycle o_req_err pulse, and produce no beats.
//
// Optional feature (macro AXI_SEQ_BACK2BACK_EN):
//   When defined, o_req_ready is also high during the final beat while
//   i_beat_ready is high, so a new burst can start without an idle cycle.
//   When undefined, o_req_ready is low for the whole BURST state.
//
// Parameters:
//   AW  address width in bits
//   DW  data-bus width in bits (power of two, 8..1024)
//
// Ports:
//   S_AXI_ACLK     clock, rising edge
//   S_AXI_ARESETN  asynchronous active-low reset
//   i_req_valid / o_req_ready         request handshake
//   i_req_addr, i_req_len, i_req_size, i_req_burst  request descriptor
//   o_req_err                         pulse: previous accepted request illegal
//   o_beat_valid / i_beat_ready       beat handshake
//   o_beat_addr, o_beat_last          current beat address and last flag
//   o_busy                            high while a burst is in progress
// ----------------------------------------------------------------------------
module axi_burst_sequencer #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          S_AXI_ACLK,
    input  logic          S_AXI_ARESETN,
    input  logic          i_req_valid,
    output logic          o_req_ready,
    input  logic [AW-1:0] i_req_addr,
    input  logic [7:0]    i_req_len,
    input  logic [2:0]    i_req_size,
    input  logic [1:0]    i_req_burst,
    output logic          o_req_err,
    output logic          o_beat_valid,
    input  logic          i_beat_ready,
    output logic [AW-1:0] o_beat_addr,
    output logic          o_beat_last,
    output logic          o_busy
);

    localparam int           DSZ       = $clog2(DW) - 3;
    localparam logic [2:0]   DSZ_L     = 3'(DSZ);
    // Low 12 bits selected: INCR bursts may only change the in-page offset.
    localparam logic [AW-1:0] PAGE_MASK = AW'(12'hFFF);

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t        state_reg;
    logic [AW-1:0] addr_reg;
    logic [7:0]    len_reg;
    logic [2:0]    size_reg;
    logic [1:0]    burst_reg;
    logic [7:0]    count_reg;
    logic          valid_reg;
    logic          last_reg;
    logic          err_reg;
    logic          ready_reg;

    // ------------------------------------------------------------------
    // Request legality
    // ------------------------------------------------------------------
    logic [7:0] req_align_m1;
    logic       wrap_len_ok;
    logic       req_illegal;

    always_comb begin
        req_align_m1 = (8'd1 << i_req_size) - 8'd1;
        wrap_len_ok  = (i_req_len == 8'd1) || (i_req_len == 8'd3) ||
                       (i_req_len == 8'd7) || (i_req_len == 8'd15);
        req_illegal  = (i_req_burst == 2'b11) ||
                       (i_req_size > DSZ_L) ||
                       ((i_req_burst == BURST_WRAP) && !wrap_len_ok) ||
                       ((i_req_burst == BURST_WRAP) &&
                        ((i_req_addr[7:0] & req_align_m1) != 8'd0));
    end

    // ------------------------------------------------------------------
    // Handshakes
    // ------------------------------------------------------------------
    logic beat_hs;
    logic last_hs;
    logic req_hs;
    logic load_req;
    logic err_req;

    assign beat_hs = valid_reg & i_beat_ready;
    assign last_hs = beat_hs & last_reg;

`ifdef AXI_SEQ_BACK2BACK_EN
    // Final beat being consumed frees the sequencer for a new request now.
    assign o_req_ready = ready_reg | last_hs;
`else
    assign o_req_ready = ready_reg;
`endif

    assign req_hs   = i_req_valid & o_req_ready;
    assign load_req = req_hs & ~req_illegal;
    assign err_req  = req_hs & req_illegal;

    // ------------------------------------------------------------------
    // Next beat address
    // ------------------------------------------------------------------
    logic [11:0]   step12;
    logic [11:0]   wrap_bytes;
    logic [AW-1:0] step;
    logic [AW-1:0] incr_sum;
    logic [AW-1:0] incr_next;
    logic [AW-1:0] wrap_mask;
    logic [AW-1:0] wrap_next;
    logic [AW-1:0] next_addr;

    always_comb begin
        step12     = 12'd1 << size_reg;
        step       = AW'(step12);
        // First beat may be unaligned; every following beat is aligned.
        incr_sum   = (addr_reg & ~(step - AW'(1))) + step;
        incr_next  = (addr_reg & ~PAGE_MASK) | (incr_sum & PAGE_MASK);
        // Legal WRAP: len+1 in {2,4,8,16}, so window is a power of two.
        wrap_bytes = (12'(len_reg) + 12'd1) << size_reg;
        wrap_mask  = AW'(wrap_bytes - 12'd1);
        wrap_next  = (addr_reg & ~wrap_mask) | ((addr_reg + step) & wrap_mask);

        case (burst_reg)
            BURST_FIXED: next_addr = addr_reg;
            BURST_INCR:  next_addr = incr_next;
            BURST_WRAP:  next_addr = wrap_next;
            default:     next_addr = addr_reg;
        endcase
    end

    // ------------------------------------------------------------------
    // State machine with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state_reg <= IDLE;
            addr_reg  <= '0;
            len_reg   <= '0;
            size_reg  <= '0;
            burst_reg <= '0;
            count_reg <= '0;
            valid_reg <= 1'b0;
            last_reg  <= 1'b0;
            err_reg   <= 1'b0;
            ready_reg <= 1'b0;
        end else begin
            err_reg <= err_req;
            if (load_req) begin
                state_reg <= BURST;
                addr_reg  <= i_req_addr;
                len_reg   <= i_req_len;
                size_reg  <= i_req_size;
                burst_reg <= i_req_burst;
                count_reg <= i_req_len;
                valid_reg <= 1'b1;
                last_reg  <= (i_req_len == 8'd0);
                ready_reg <= 1'b0;
            end else if (state_reg == IDLE) begin
                ready_reg <= 1'b1;
            end else if (beat_hs) begin
                if (!last_reg) begin
                    addr_reg  <= next_addr;
                    count_reg <= count_reg - 8'd1;
                    last_reg  <= (count_reg == 8'd1);
                end else begin
                    state_reg <= IDLE;
                    valid_reg <= 1'b0;
                    last_reg  <= 1'b0;
                    ready_reg <= 1'b1;
                end
            end
        end
    end

    assign o_beat_valid = valid_reg;
    assign o_beat_addr  = addr_reg;
    assign o_beat_last  = last_reg;
    assign o_req_err    = err_reg;
    assign o_busy       = (state_reg == BURST);

endmodule

// File: tb/tb_axi_burst_sequencer.sv
// ----------------------------------------------------------------------------
// tb_axi_burst_sequencer
//
// Self-checking bench for axi_burst_sequencer (AW=32, DW=32). A table of
// directed burst descriptors with hand-computed beat addresses is applied in
// a loop; stalls, reset mid-burst and back-to-back behaviour are exercised
// by hand-written sequences. Inputs change on the falling edge and outputs
// are sampled shortly after it.
// ----------------------------------------------------------------------------
module tb_axi_burst_sequencer;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [7:0]  req_len;
    logic [2:0]  req_size;
    logic [1:0]  req_burst;
    logic        req_err;
    logic        beat_valid;
    logic        beat_ready;
    logic [31:0] beat_addr;
    logic        beat_last;
    logic        busy;

    int errors = 0;
    int checks = 0;

    axi_burst_sequencer #(.AW(32), .DW(32)) dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .i_req_valid   (req_valid),
        .o_req_ready   (req_ready),
        .i_req_addr    (req_addr),
        .i_req_len     (req_len),
        .i_req_size    (req_size),
        .i_req_burst   (req_burst),
        .o_req_err     (req_err),
        .o_beat_valid  (beat_valid),
        .i_beat_ready  (beat_ready),
        .o_beat_addr   (beat_addr),
        .o_beat_last   (beat_last),
        .o_busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Move to the next falling edge and let combinational outputs settle.
    task automatic step_neg();
        @(negedge clk);
        #1;
    endtask

    typedef struct packed {
        logic [31:0]       addr;
        logic [7:0]        len;
        logic [2:0]        size;
        logic [1:0]        burst;
        logic              err;
        logic [2:0]        n;
        logic [3:0][31:0]  exp;
    } vec_t;

    vec_t vecs[11];

    // Issue one request with i_beat_ready held high and check every beat.
    task automatic run_vec(input int idx, input vec_t v);
        @(negedge clk);
        chk($sformatf("v%0d ready_before", idx), 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_addr   = v.addr;
        req_len    = v.len;
        req_size   = v.size;
        req_burst  = v.burst;
        beat_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        if (v.err) begin
            chk($sformatf("v%0d err_pulse", idx), 32'(req_err), 32'd1);
            chk($sformatf("v%0d err_no_beat", idx), 32'(beat_valid), 32'd0);
            chk($sformatf("v%0d err_ready", idx), 32'(req_ready), 32'd1);
            step_neg();
            chk($sformatf("v%0d err_once", idx), 32'(req_err), 32'd0);
            chk($sformatf("v%0d err_no_beat2", idx), 32'(beat_valid), 32'd0);
            $display("vec %0d: addr=0x%08h len=%0d size=%0d burst=%0d -> error", idx,
                     v.addr, v.len, v.size, v.burst);
        end else begin
            for (int k = 0; k < int'(v.n); k++) begin
                chk($sformatf("v%0d b%0d valid", idx, k), 32'(beat_valid), 32'd1);
                chk($sformatf("v%0d b%0d addr", idx, k), beat_addr, v.exp[k]);
                chk($sformatf("v%0d b%0d last", idx, k), 32'(beat_last),
                    32'(k == int'(v.n) - 1));
                chk($sformatf("v%0d b%0d busy", idx, k), 32'(busy), 32'd1);
`ifdef AXI_SEQ_BACK2BACK_EN
                chk($sformatf("v%0d b%0d ready", idx, k), 32'(req_ready),
                    32'(k == int'(v.n) - 1));
`else
                chk($sformatf("v%0d b%0d ready", idx, k), 32'(req_ready), 32'd0);
`endif
                chk($sformatf("v%0d b%0d err", idx, k), 32'(req_err), 32'd0);
                step_neg();
            end
            chk($sformatf("v%0d done_valid", idx), 32'(beat_valid), 32'd0);
            chk($sformatf("v%0d done_busy", idx), 32'(busy), 32'd0);
            chk($sformatf("v%0d done_ready", idx), 32'(req_ready), 32'd1);
            $display("vec %0d: addr=0x%08h len=%0d size=%0d burst=%0d -> %0d beats", idx,
                     v.addr, v.len, v.size, v.burst, v.n);
        end
    endtask

    initial begin
        int beats_done;
        int cyc;

        // {addr, len, size, burst, err, n, {beat3, beat2, beat1, beat0}}
        vecs[0]  = '{32'h0000_1004, 8'd3, 3'd2, 2'b01, 1'b0, 3'd4,
                     {32'h0000_1010, 32'h0000_100C, 32'h0000_1008, 32'h0000_1004}};
        vecs[1]  = '{32'h0000_0038, 8'd3, 3'd2, 2'b10, 1'b0, 3'd4,
                     {32'h0000_0034, 32'h0000_0030, 32'h0000_003C, 32'h0000_0038}};
        vecs[2]  = '{32'h0000_0FFC, 8'd1, 3'd2, 2'b01, 1'b0, 3'd2,
                     {32'h0, 32'h0, 32'h0000_0000, 32'h0000_0FFC}};
        vecs[3]  = '{32'hABCD_EFFC, 8'd1, 3'd2, 2'b01, 1'b0, 3'd2,
                     {32'h0, 32'h0, 32'hABCD_E000, 32'hABCD_EFFC}};
        vecs[4]  = '{32'h0000_1001, 8'd2, 3'd2, 2'b01, 1'b0, 3'd3,
                     {32'h0, 32'h0000_1008, 32'h0000_1004, 32'h0000_1001}};
        vecs[5]  = '{32'h0000_0108, 8'd1, 3'd3, 2'b10, 1'b1, 3'd0,
                     {32'h0, 32'h0, 32'h0, 32'h0}};  // size 3 exceeds 32-bit bus
        vecs[6]  = '{32'h0000_0005, 8'd1, 3'd0, 2'b10, 1'b0, 3'd2,
                     {32'h0, 32'h0, 32'h0000_0004, 32'h0000_0005}};
        vecs[7]  = '{32'h0000_0007, 8'd0, 3'd0, 2'b01, 1'b0, 3'd1,
                     {32'h0, 32'h0, 32'h0, 32'h0000_0007}};
        vecs[8]  = '{32'h0000_0100, 8'd1, 3'd2, 2'b11, 1'b1, 3'd0,
                     {32'h0, 32'h0, 32'h0, 32'h0}};
        vecs[9]  = '{32'h0000_0100, 8'd2, 3'd2, 2'b10, 1'b1, 3'd0,
                     {32'h0, 32'h0, 32'h0, 32'h0}};
        vecs[10] = '{32'h0000_003A, 8'd3, 3'd2, 2'b10, 1'b1, 3'd0,
                     {32'h0, 32'h0, 32'h0, 32'h0}};

        req_valid  = 1'b0;
        req_addr   = '0;
        req_len    = '0;
        req_size   = '0;
        req_burst  = '0;
        beat_ready = 1'b0;
        rst_n      = 1'b1;
        #2 rst_n   = 1'b0;

        // Reset state
        step_neg();
        step_neg();
        chk("rst ready", 32'(req_ready), 32'd0);
        chk("rst valid", 32'(beat_valid), 32'd0);
        chk("rst last", 32'(beat_last), 32'd0);
        chk("rst err", 32'(req_err), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst addr", beat_addr, 32'd0);
        rst_n = 1'b1;
        step_neg();
        chk("post-rst ready", 32'(req_ready), 32'd1);
        $display("reset: checked");

        for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

        // FIXED burst with i_beat_ready low on alternate cycles
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h0000_0200; req_len = 8'd2;
        req_size  = 3'd2; req_burst = 2'b00; beat_ready = 1'b0;
        @(negedge clk);
        req_valid  = 1'b0;
        beats_done = 0;
        cyc        = 0;
        while (beats_done < 3 && cyc < 20) begin
            beat_ready = (cyc % 2 == 1);
            #1;
            chk($sformatf("fixed c%0d valid", cyc), 32'(beat_valid), 32'd1);
            chk($sformatf("fixed c%0d addr", cyc), beat_addr, 32'h0000_0200);
            chk($sformatf("fixed c%0d last", cyc), 32'(beat_last), 32'(beats_done == 2));
            if (beat_ready) beats_done++;
            cyc++;
            @(negedge clk);
        end
        chk("fixed beat count", 32'(beats_done), 32'd3);
        beat_ready = 1'b1;
        #1;
        chk("fixed done valid", 32'(beat_valid), 32'd0);
        $display("fixed stall: %0d beats in %0d cycles", beats_done, cyc);

        // Reset dropped mid-burst at beat 2 of 8
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h0000_0000; req_len = 8'd7;
        req_size  = 3'd2; req_burst = 2'b01; beat_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        step_neg();
        step_neg();
        chk("midrst beat2 addr", beat_addr, 32'h0000_0008);
        rst_n = 1'b0;
        #1;
        chk("midrst valid", 32'(beat_valid), 32'd0);
        chk("midrst busy", 32'(busy), 32'd0);
        chk("midrst ready", 32'(req_ready), 32'd0);
        chk("midrst addr", beat_addr, 32'd0);
        step_neg();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step_neg();
            chk($sformatf("midrst after%0d valid", k), 32'(beat_valid), 32'd0);
            chk($sformatf("midrst after%0d ready", k), 32'(req_ready), 32'd1);
        end
        $display("reset mid-burst: checked");

`ifdef AXI_SEQ_BACK2BACK_EN
        // Two single-beat requests back to back
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h0000_0040; req_len = 8'd0;
        req_size  = 3'd2; req_burst = 2'b01; beat_ready = 1'b1;
        @(negedge clk);
        req_addr = 32'h0000_0080;
        #1;
        chk("b2b b0 valid", 32'(beat_valid), 32'd1);
        chk("b2b b0 addr", beat_addr, 32'h0000_0040);
        chk("b2b b0 ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        chk("b2b b1 valid", 32'(beat_valid), 32'd1);
        chk("b2b b1 addr", beat_addr, 32'h0000_0080);
        chk("b2b b1 last", 32'(beat_last), 32'd1);
        step_neg();
        chk("b2b done valid", 32'(beat_valid), 32'd0);
        $display("back-to-back: checked");
`else
        // Without back-to-back, a request held during the last beat waits
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h0000_0040; req_len = 8'd0;
        req_size  = 3'd2; req_burst = 2'b01; beat_ready = 1'b1;
        @(negedge clk);
        req_addr = 32'h0000_0080;
        #1;
        chk("nob2b b0 addr", beat_addr, 32'h0000_0040);
        chk("nob2b b0 ready", 32'(req_ready), 32'd0);
        step_neg();
        chk("nob2b gap valid", 32'(beat_valid), 32'd0);
        chk("nob2b gap ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        chk("nob2b b1 valid", 32'(beat_valid), 32'd1);
        chk("nob2b b1 addr", beat_addr, 32'h0000_0080);
        step_neg();
        chk("nob2b done valid", 32'(beat_valid), 32'd0);
        $display("idle gap between bursts: checked");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
